// File: rtl/param_decoder_pipe_if.sv
// Request/result bundle for param_decoder_pipe: select-side valid/ready
// handshake and the one-hot result handshake toward the consumer.
interface param_decoder_pipe_if #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic               in_en;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OUT-1:0] out_y;
  logic               out_err;

  modport master (
    output in_valid, in_sel, in_en, out_ready,
    input  in_ready, out_valid, out_y, out_err
  );

  modport slave (
    input  in_valid, in_sel, in_en, out_ready,
    output in_ready, out_valid, out_y, out_err
  );
endinterface

// File: rtl/param_decoder_pipe.sv
// Registered SEL_W-to-NUM_OUT one-hot decoder with enable, out-of-range flag
// and valid/ready on both sides. Define DEC_SKID_EN for a registered in_ready.
module param_decoder_pipe #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  param_decoder_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } st_e;

  st_e                st_q, st_d;
  logic [NUM_OUT-1:0] y_p1_q, y_p1_d;
  logic               err_p1_q, err_p1_d;
  logic [NUM_OUT-1:0] dec_y;
  logic               dec_err;
  logic               vld_p1;
  logic               in_rdy;
  logic               in_fire;
  logic               out_fire;

  function automatic logic [NUM_OUT-1:0] decode_y(input logic en,
                                                 input logic [SEL_W-1:0] sel);
    logic [31:0] sel_ext;
    sel_ext  = 32'(sel);
    decode_y = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      decode_y[i] = en && (sel_ext == 32'(i));
    end
  endfunction

  // Select is compared at full width, so any value past NUM_OUT-1 is an error.
  function automatic logic decode_err(input logic en,
                                      input logic [SEL_W-1:0] sel);
    decode_err = en && (32'(sel) >= 32'(NUM_OUT));
  endfunction

  always_comb begin
    dec_y   = decode_y(bus.in_en, bus.in_sel);
    dec_err = decode_err(bus.in_en, bus.in_sel);
  end

  assign vld_p1   = (st_q != EMPTY);
  assign in_fire  = bus.in_valid && in_rdy;
  assign out_fire = vld_p1 && bus.out_ready;

`ifdef DEC_SKID_EN
  logic [NUM_OUT-1:0] y_p0_q, y_p0_d;
  logic               err_p0_q, err_p0_d;
  logic               rdy_q, rdy_d;

  assign in_rdy = rdy_q;

  always_comb begin
    st_d     = st_q;
    y_p1_d   = y_p1_q;
    err_p1_d = err_p1_q;
    y_p0_d   = y_p0_q;
    err_p0_d = err_p0_q;
    case (st_q)
      EMPTY: begin
        if (in_fire) begin
          st_d     = FULL;
          y_p1_d   = dec_y;
          err_p1_d = dec_err;
        end
      end
      FULL: begin
        if (out_fire && in_fire) begin
          y_p1_d   = dec_y;
          err_p1_d = dec_err;
        end else if (out_fire) begin
          st_d = EMPTY;
        end else if (in_fire) begin
          // Consumer stalled: park the new result behind the output stage.
          st_d     = SKID;
          y_p0_d   = dec_y;
          err_p0_d = dec_err;
        end
      end
      SKID: begin
        if (out_fire) begin
          st_d     = FULL;
          y_p1_d   = y_p0_q;
          err_p1_d = err_p0_q;
        end
      end
      default: st_d = EMPTY;
    endcase
    rdy_d = (st_d != SKID);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= EMPTY;
      y_p1_q   <= '0;
      err_p1_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      st_q     <= st_d;
      y_p1_q   <= y_p1_d;
      err_p1_q <= err_p1_d;
      rdy_q    <= rdy_d;
    end
  end

  // Skid payload is only meaningful in SKID, so it needs no reset.
  always_ff @(posedge clk) begin
    y_p0_q   <= y_p0_d;
    err_p0_q <= err_p0_d;
  end
`else
  assign in_rdy = !vld_p1 || bus.out_ready;

  always_comb begin
    st_d     = st_q;
    y_p1_d   = y_p1_q;
    err_p1_d = err_p1_q;
    case (st_q)
      EMPTY: begin
        if (in_fire) begin
          st_d     = FULL;
          y_p1_d   = dec_y;
          err_p1_d = dec_err;
        end
      end
      FULL: begin
        if (out_fire) begin
          if (in_fire) begin
            y_p1_d   = dec_y;
            err_p1_d = dec_err;
          end else begin
            st_d = EMPTY;
          end
        end
      end
      default: st_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= EMPTY;
      y_p1_q   <= '0;
      err_p1_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      y_p1_q   <= y_p1_d;
      err_p1_q <= err_p1_d;
    end
  end
`endif

  // Output stage boundary: every result-side port comes straight from flops.
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_p1;
  assign bus.out_y     = y_p1_q;
  assign bus.out_err   = err_p1_q;

endmodule

// File: tb/tb_param_decoder_pipe.sv
// Directed bench for param_decoder_pipe: an 8-output and a 6-output instance,
// followed by a random-stall scoreboard run on the 6-output instance.
module tb_param_decoder_pipe;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [6:0] sb_q[$];

  param_decoder_pipe_if #(.SEL_W(3), .NUM_OUT(8)) bus8 ();
  param_decoder_pipe_if #(.SEL_W(3), .NUM_OUT(6)) bus6 ();

  param_decoder_pipe #(.SEL_W(3), .NUM_OUT(8)) u_dec8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  param_decoder_pipe #(.SEL_W(3), .NUM_OUT(6)) u_dec6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] model6(input logic en, input logic [2:0] sel);
    if (!en)          model6 = 7'h00;
    else if (sel > 5) model6 = 7'h40;
    else              model6 = {1'b0, 6'(6'd1 << sel)};
  endfunction

  initial begin
    logic [6:0] exp_r;
    logic       pushed;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_sel = '0; bus8.in_en = 1'b0; bus8.out_ready = 1'b1;
    bus6.in_valid = 1'b0; bus6.in_sel = '0; bus6.in_en = 1'b0; bus6.out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_valid8", bus8.out_valid, 0);
    chk("rst_y8",     bus8.out_y,     0);
    chk("rst_err8",   bus8.out_err,   0);
    chk("rst_ready8", bus8.in_ready,  1);
    chk("rst_valid6", bus6.out_valid, 0);
    chk("rst_ready6", bus6.in_ready,  1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Full sweep, back-to-back, one cycle latency
    bus8.in_valid = 1'b1;
    bus8.in_en    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus8.in_sel = 3'(i);
      tick();
      chk("sweep_valid", bus8.out_valid, 1);
      chk("sweep_y",     bus8.out_y,     32'd1 << i);
      chk("sweep_err",   bus8.out_err,   0);
    end
    bus8.in_valid = 1'b0;
    tick();
    chk("sweep_drain_valid", bus8.out_valid, 0);

    // Enable low
    bus8.in_valid = 1'b1; bus8.in_en = 1'b0; bus8.in_sel = 3'd5;
    tick();
    bus8.in_valid = 1'b0;
    chk("en0_valid", bus8.out_valid, 1);
    chk("en0_y",     bus8.out_y,     0);
    chk("en0_err",   bus8.out_err,   0);
    tick();
    chk("en0_drain_valid", bus8.out_valid, 0);

    // Out-of-range on the 6-output instance
    bus6.in_valid = 1'b1; bus6.in_en = 1'b1; bus6.in_sel = 3'd6;
    tick();
    bus6.in_sel = 3'd7;
    chk("oor6_valid", bus6.out_valid, 1);
    chk("oor6_y",     bus6.out_y,     0);
    chk("oor6_err",   bus6.out_err,   1);
    tick();
    bus6.in_sel = 3'd5;
    chk("oor7_y",   bus6.out_y,   0);
    chk("oor7_err", bus6.out_err, 1);
    tick();
    bus6.in_valid = 1'b0;
    chk("sel5_y",   bus6.out_y,   32'h20);
    chk("sel5_err", bus6.out_err, 0);
    tick();
    chk("oor_drain_valid", bus6.out_valid, 0);

    // Backpressure: out_ready low for four edges while offering 1,2,3
    bus8.out_ready = 1'b0;
    bus8.in_valid = 1'b1; bus8.in_en = 1'b1; bus8.in_sel = 3'd1;
    tick();
    bus8.in_sel = 3'd2;
    #1;
    chk("bp_y_a", bus8.out_y, 32'h02);
`ifdef DEC_SKID_EN
    chk("bp_ready_a", bus8.in_ready, 1);
`else
    chk("bp_ready_a", bus8.in_ready, 0);
`endif
    tick();
`ifdef DEC_SKID_EN
    bus8.in_sel = 3'd3;
`endif
    chk("bp_y_b",     bus8.out_y,    32'h02);
    chk("bp_ready_b", bus8.in_ready, 0);
    tick();
    chk("bp_y_c",     bus8.out_y,    32'h02);
    chk("bp_ready_c", bus8.in_ready, 0);
    tick();
    chk("bp_y_d",     bus8.out_y,    32'h02);
    chk("bp_valid_d", bus8.out_valid, 1);
    bus8.out_ready = 1'b1;
    #1;
`ifdef DEC_SKID_EN
    chk("bp_ready_rel", bus8.in_ready, 0);
`else
    chk("bp_ready_rel", bus8.in_ready, 1);
`endif
    tick();
`ifndef DEC_SKID_EN
    bus8.in_sel = 3'd3;
`endif
    chk("bp_out_2", bus8.out_y,    32'h04);
    chk("bp_ready_e", bus8.in_ready, 1);
    tick();
    bus8.in_valid = 1'b0;
    chk("bp_out_3", bus8.out_y,    32'h08);
    chk("bp_valid_3", bus8.out_valid, 1);
    tick();
    chk("bp_drain_valid", bus8.out_valid, 0);

    // Reset mid-stream with a held result
    bus8.out_ready = 1'b0;
    bus8.in_valid = 1'b1; bus8.in_en = 1'b1; bus8.in_sel = 3'd4;
    tick();
    bus8.in_valid = 1'b0;
    chk("mid_y_before", bus8.out_y, 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus8.out_valid, 0);
    chk("mid_rst_y",     bus8.out_y,     0);
    chk("mid_rst_err",   bus8.out_err,   0);
    chk("mid_rst_ready", bus8.in_ready,  1);
    tick();
    rst_n = 1'b1;
    bus8.out_ready = 1'b1;
    tick();
    chk("mid_after_valid", bus8.out_valid, 0);

    // Random stall with in-order scoreboard on the 6-output instance
    for (int c = 0; c < 10000; c++) begin
      bus6.in_valid  = 1'($urandom_range(0, 1));
      bus6.in_en     = ($urandom_range(0, 7) != 0);
      bus6.in_sel    = 3'($urandom_range(0, 7));
      bus6.out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_onehot", 32'($onehot0(bus6.out_y)), 1);
      pushed = bus6.in_valid && bus6.in_ready;
      if (bus6.out_valid && bus6.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("rnd_unexpected", 1, 0);
        end else begin
          exp_r = sb_q.pop_front();
          chk("rnd_result", {bus6.out_err, bus6.out_y}, 32'(exp_r));
        end
      end
      if (pushed) sb_q.push_back(model6(bus6.in_en, bus6.in_sel));
      tick();
    end
    bus6.in_valid  = 1'b0;
    bus6.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (bus6.out_valid) begin
        if (sb_q.size() == 0) begin
          chk("drain_unexpected", 1, 0);
        end else begin
          exp_r = sb_q.pop_front();
          chk("drain_result", {bus6.out_err, bus6.out_y}, 32'(exp_r));
        end
      end
      tick();
    end
    chk("sb_empty", 32'(sb_q.size()), 0);
    chk("rnd_final_valid", bus6.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_decoder_pipe.md
# param_decoder_pipe

Parametrised, registered SEL_W-to-NUM_OUT one-hot decoder with an enable input and valid/ready flow control on both sides. It generalises our gate-level 1-to-2 enable decoder to arbitrary select width, adds a one-cycle output register stage and backpressure, and flags out-of-range selects. It sits between a select-producing controller and downstream one-hot consumers (row/bank enables, mux controls) that may stall.

## Interface
- SEL_W, default 3: select width in bits; legal range 1..8.
- NUM_OUT, default 8: number of one-hot outputs; legal range 2..2**SEL_W.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request present.
- in_ready  output  1  block accepts the request this cycle.
- in_sel  input  SEL_W  index of the output to assert.
- in_en  input  1  decoder enable; 0 decodes to all-zero.
- out_valid  output  1  out_y/out_err hold a result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_y  output  NUM_OUT  one-hot (or all-zero) decoded word.
- out_err  output  1  result came from in_sel >= NUM_OUT with in_en=1.

## Operation
- Input handshake completes when in_valid && in_ready; output handshake when out_valid && out_ready.
- Decode per accepted request: in_en=0 -> out_y=0, out_err=0; in_en=1 and in_sel<NUM_OUT -> out_y has only bit in_sel set, out_err=0; in_en=1 and in_sel>=NUM_OUT -> out_y=0, out_err=1.
- in_sel compared unsigned at SEL_W bits; no truncation, no wrap.
- Output stage states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY + input fire -> FULL with new result.
  - FULL + output fire, no input fire -> EMPTY.
  - FULL + output fire + input fire -> FULL with new result (back-to-back).
  - FULL + no output fire -> hold out_y/out_err/out_valid unchanged.
- Results delivered strictly in acceptance order; none dropped or duplicated.
- Reset (any time, including mid-transfer): out_valid=0, out_y=0, out_err=0, in_ready=1, any buffered result discarded.

## Timing
- Latency: input fire in cycle n -> out_valid=1 with the result in cycle n+1.
- Throughput: one result per cycle while out_ready=1.
- out_y, out_err, out_valid driven directly from flops; never combinational from inputs.
- out_valid, once high, stays high and the payload is stable until output fire.
- in_valid may drop without fire; the block imposes no hold rule on the producer.

## Configuration
- DEC_SKID_EN defined: two-entry skid buffer. in_ready is a flop output (1 when the skid slot is empty), with no combinational path from out_ready. An input fire while FULL and out_ready=0 lands in the skid slot; in_ready drops the next cycle. On the next output fire the skid entry moves to the output stage and in_ready returns to 1 the following cycle. Latency 1 through an empty stage.
- DEC_SKID_EN undefined: single stage. in_ready = !out_valid || out_ready (combinational). No skid storage.
- Decode, error, reset and ordering rules are identical in both builds.

## Test plan
- Reset mid-stream: SEL_W=3, NUM_OUT=8, out_valid=1 with out_y=8'h10; pulse rst_n low -> out_valid=0, out_y=0, out_err=0, in_ready=1 immediately, before any clk edge.
- Full sweep: in_en=1, in_sel=0..7 back-to-back, out_ready=1 -> out_y=8'h01,8'h02,...,8'h80 on consecutive cycles, each one cycle after its input fire, out_err=0.
- Enable low: in_en=0, in_sel=5 -> out_y=0, out_err=0, out_valid=1 for one cycle.
- Out-of-range: SEL_W=3, NUM_OUT=6, in_en=1, in_sel=6 then 7 -> out_y=0, out_err=1 for both; in_sel=5 -> out_y=6'h20, out_err=0.
- Backpressure: hold out_ready=0 for 4 cycles while offering in_sel=1,2,3 -> out_y stays 8'h02. Without DEC_SKID_EN, in_ready=0 while FULL. With DEC_SKID_EN, in_sel=2 is also accepted and in_ready then stays 0. Releasing out_ready delivers 8'h02, 8'h04, 8'h08 in order with no loss or duplication.
- Random stall: random in_valid/out_ready over 10,000 cycles -> scoreboard matches every result in order and out_y is never multi-hot.
